// File: rtl/fetch_redirect_pkg.sv
// Shared fetch-stage definitions: reset PC, nop encoding, instruction-memory
// address window and the next-PC select encoding used by fetch_npc.
package fetch_redirect_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Instruction memory spans PC_RESET .. PC_RESET + IM_SPAN inclusive.
    localparam logic [31:0] IM_SPAN = 32'h0000_6FFF;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_disp(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC selection: jr > j > taken branch > sequential.
// A nullified delay slot (flush) only ever continues sequentially, unless a
// taken branch is asserted alongside it, in which case the branch target wins.
module fetch_npc
    import fetch_redirect_pkg::*;
(
    input  logic [31:0] F_PC,
    input  logic [31:0] D_PC,
    input  logic        D_isBranch,
    input  logic        D_flush,
    input  logic        D_isJump,
    input  logic        D_isJr,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_index26,
    input  logic [31:0] D_jrTarget,
    output logic [31:0] npc
);

    npc_sel_e sel;

    // Pick the redirect source by priority.
    always_comb begin
        sel = NPC_SEQ;
        if (D_flush) begin
            if (D_isBranch) sel = NPC_BR;
        end else if (D_isJr) begin
            sel = NPC_JR;
        end else if (D_isJump) begin
            sel = NPC_J;
        end else if (D_isBranch) begin
            sel = NPC_BR;
        end
    end

    // Form the selected target; redirects are relative to the D-stage PC.
    always_comb begin
        npc = F_PC + 32'd4;
        case (sel)
            NPC_JR:  npc = D_jrTarget;
            NPC_J:   npc = {D_PC[31:28], D_index26, 2'b00};
            NPC_BR:  npc = D_PC + 32'd4 + branch_disp(D_imm16);
            default: npc = F_PC + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch-stage PC register and IF/ID pipeline register.
// Optional macro FETCH_ADEL_EN adds F_adel: an instruction-fetch address
// error flag (misaligned or outside the IM window) carried alongside IF/ID.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic        D_isBranch,
    input  logic        D_flush,
    input  logic        D_isJump,
    input  logic        D_isJr,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_index26,
    input  logic [31:0] D_jrTarget,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr
`ifdef FETCH_ADEL_EN
    ,
    output logic        F_adel
`endif
);

    logic [31:0] npc;
    logic        fetch_fault;

    fetch_npc u_npc (
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_isBranch (D_isBranch),
        .D_flush    (D_flush),
        .D_isJump   (D_isJump),
        .D_isJr     (D_isJr),
        .D_imm16    (D_imm16),
        .D_index26  (D_index26),
        .D_jrTarget (D_jrTarget),
        .npc        (npc)
    );

`ifdef FETCH_ADEL_EN
    // Fetch address error: misaligned or outside the instruction memory.
    always_comb begin
        fetch_fault = (F_PC[1:0] != 2'b00)
                   || (F_PC < PC_RESET)
                   || (F_PC > (PC_RESET + IM_SPAN));
    end
`else
    assign fetch_fault = 1'b0;
`endif

    // PC and IF/ID update; stall freezes everything and ignores D-stage controls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            F_PC    <= PC_RESET;
            D_PC    <= PC_RESET;
            D_instr <= NOP_WORD;
`ifdef FETCH_ADEL_EN
            F_adel  <= 1'b0;
`endif
        end else if (!stall) begin
            F_PC <= npc;
            D_PC <= F_PC;
            if (D_flush || fetch_fault) begin
                D_instr <= NOP_WORD;
            end else begin
                D_instr <= F_instr;
            end
`ifdef FETCH_ADEL_EN
            F_adel <= fetch_fault && !D_flush;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_redirect.sv
// Randomised scoreboard bench for fetch_redirect: the driver updates a
// behavioural fetch model and queues the expected register state for each
// edge; an independent monitor pops and compares after every edge.
module tb_fetch_redirect;

    localparam logic [31:0] PCR = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, D_isBranch, D_flush, D_isJump, D_isJr;
    logic [31:0] F_instr, D_jrTarget;
    logic [15:0] D_imm16;
    logic [25:0] D_index26;
    logic [31:0] F_PC, D_PC, D_instr;
    logic        adel_obs;

    always #5 clk = ~clk;

    fetch_redirect dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .F_instr    (F_instr),
        .D_isBranch (D_isBranch),
        .D_flush    (D_flush),
        .D_isJump   (D_isJump),
        .D_isJr     (D_isJr),
        .D_imm16    (D_imm16),
        .D_index26  (D_index26),
        .D_jrTarget (D_jrTarget),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_instr    (D_instr)
`ifdef FETCH_ADEL_EN
        ,
        .F_adel     (adel_obs)
`endif
    );

`ifndef FETCH_ADEL_EN
    assign adel_obs = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] fpc;
        logic [31:0] dpc;
        logic [31:0] dins;
        logic        adel;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Architectural view of the fetch stage
    logic [31:0] m_fpc, m_dpc, m_dins;
    logic        m_adel;

    function automatic bit addr_bad(input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
        longint unsigned a;
        a = pc;
        return (a % 4 != 0) || (a < PCR) || (a > PCR + 32'h6FFF);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: apply inputs at negedge, advance the model, queue expectation.
    task automatic cyc(input logic rst, input logic st, input logic fl,
                       input logic br, input logic j, input logic jr,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] jrt, input logic [31:0] ins);
        logic [31:0] target;
        int          off;
        exp_t        e;
        @(negedge clk);
        reset = rst; stall = st; D_flush = fl; D_isBranch = br;
        D_isJump = j; D_isJr = jr; D_imm16 = imm; D_index26 = idx;
        D_jrTarget = jrt; F_instr = ins;
        if (!rst) begin
            m_fpc = PCR; m_dpc = PCR; m_dins = NOP; m_adel = 1'b0;
        end else if (!st) begin
            off = int'($signed(imm)) * 4;
            if (br)                target = m_dpc + 32'd4 + 32'(off);
            else if (fl)           target = m_fpc + 32'd4;
            else if (jr)           target = jrt;
            else if (j)            target = {m_dpc[31:28], idx, 2'b00};
            else                   target = m_fpc + 32'd4;
            if (!fl && jr)         target = jrt;
            else if (!fl && j)     target = {m_dpc[31:28], idx, 2'b00};
            m_adel = !fl && addr_bad(m_fpc);
            m_dins = (fl || m_adel) ? NOP : ins;
            m_dpc  = m_fpc;
            m_fpc  = target;
        end
        e.fpc = m_fpc; e.dpc = m_dpc; e.dins = m_dins; e.adel = m_adel;
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT registers against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (F_PC !== e.fpc) begin
                    n_bad++;
                    $display("FAIL f_pc t=%0t: got %h want %h", $time, F_PC, e.fpc);
                end
                n_cmp++;
                if (D_PC !== e.dpc) begin
                    n_bad++;
                    $display("FAIL d_pc t=%0t: got %h want %h", $time, D_PC, e.dpc);
                end
                n_cmp++;
                if (D_instr !== e.dins) begin
                    n_bad++;
                    $display("FAIL d_instr t=%0t: got %h want %h", $time, D_instr, e.dins);
                end
`ifdef FETCH_ADEL_EN
                n_cmp++;
                if (adel_obs !== e.adel) begin
                    n_bad++;
                    $display("FAIL f_adel t=%0t: got %b want %b", $time, adel_obs, e.adel);
                end
`endif
            end
        end
    end

    initial begin
        logic        st, fl, br, j, jr;
        logic [31:0] jrt;
        reset = 1'b0; stall = 1'b0; D_flush = 1'b0; D_isBranch = 1'b0;
        D_isJump = 1'b0; D_isJr = 1'b0; D_imm16 = '0; D_index26 = '0;
        D_jrTarget = '0; F_instr = '0;
        m_fpc = PCR; m_dpc = PCR; m_dins = NOP; m_adel = 1'b0;

        // Reset, release, sequential fetch
        cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2408_0001);
        cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2408_0001);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2408_0001);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h1000_0003);
        // Taken branch at D_PC=0x3004, +3 words -> 0x3014; delay slot enters D
        cyc(1, 0, 0, 1, 0, 0, 16'h0003, 26'h0, 32'h0, 32'h2409_0002);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h1000_FFFF);
        // Negative offset: target equals D_PC
        cyc(1, 0, 0, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 32'h240A_0003);
        // Likely branch not taken: delay slot nullified
        cyc(1, 0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h240B_0004);
        // Stall with stale flush+branch for two cycles, then apply once
        cyc(1, 1, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'hDEAD_BEEF);
        cyc(1, 1, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'hDEAD_BEEF);
        cyc(1, 0, 1, 1, 0, 0, 16'h0002, 26'h0, 32'h0, 32'h240C_0005);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h240D_0006);
        // jr beats a simultaneous branch
        cyc(1, 0, 0, 1, 0, 1, 16'h0040, 26'h0, 32'h0000_3100, 32'h240E_0007);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h240F_0008);
        // Jump keeps D_PC[31:28]
        cyc(1, 0, 0, 0, 1, 0, 16'h0, 26'h0000_C40, 32'h0, 32'h2410_0009);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2411_000A);
        // Misaligned jr target: fetched as-is, or flagged when ADEL is built in
        cyc(1, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0000_3102, 32'h2412_000B);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2413_000C);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h2414_000D);
        cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);

        // Random traffic; flush never combined with j/jr (undefined upstream)
        for (int i = 0; i < 500; i++) begin
            st = ($urandom_range(0, 99) < 20);
            jr = ($urandom_range(0, 99) < 10);
            j  = ($urandom_range(0, 99) < 10);
            br = ($urandom_range(0, 99) < 20);
            fl = !jr && !j && ($urandom_range(0, 99) < 15);
            jrt = PCR + (32'($urandom_range(0, 32'h6FFF)) & 32'hFFFF_FFFC);
            if ($urandom_range(0, 99) < 10) jrt = jrt | 32'($urandom_range(1, 3));
            cyc(($urandom_range(0, 99) >= 2), st, fl, br, j, jr,
                16'($urandom_range(0, 16'hFFFF)),
                26'($urandom_range(32'h0000_0C00, 32'h0000_2BFF)),
                jrt, $urandom());
        end

        cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- F-stage PC register plus IF/ID pipeline register; the consumer of the D-stage comparator's `isBranch`/`flush` outputs.
- Computes the next PC from branch/jump decisions resolved in D.
- Honours the delay slot: the instruction fetched alongside a D-stage branch always enters D, except for likely-style branches (`bsveall`) that are not taken, where `D_flush` nullifies it into a nop.
- Drives the instruction-memory address and feeds the decoder.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- F_instr  input  32  instruction read combinationally from IM at F_PC.
- D_isBranch  input  1  D-stage branch taken.
- D_flush  input  1  nullify delay slot (likely branch not taken).
- D_isJump  input  1  j/jal in D.
- D_isJr  input  1  jr/jalr in D.
- D_imm16  input  16  branch offset of the D instruction.
- D_index26  input  26  jump index of the D instruction.
- D_jrTarget  input  32  forwarded rs value of the D instruction.
- F_PC  output  32  current fetch address to IM.
- D_PC  output  32  PC of the instruction held in IF/ID.
- D_instr  output  32  instruction held in IF/ID.

Behaviour:
- Reset (reset==0 at posedge): F_PC=PC_RESET, D_PC=PC_RESET, D_instr=NOP_WORD. Reset overrides stall and all redirects.
- NPC selection, combinational, priority high to low:
  - D_isJr: D_jrTarget.
  - D_isJump: {D_PC[31:28], D_index26, 2'b00}.
  - D_isBranch: D_PC + 4 + (sign-extended D_imm16 << 2), 32-bit wraparound.
  - Otherwise: F_PC + 4.
- Redirect targets use D_PC. The delay slot is the instruction at F_PC == D_PC+4 and is never refetched.
- stall==1: F_PC, D_PC and D_instr all hold. D_isBranch, D_flush, D_isJump and D_isJr are ignored, because D operands may be stale.
- stall==0, D_flush==0: F_PC<=NPC; D_PC<=F_PC; D_instr<=F_instr.
- stall==0, D_flush==1: F_PC<=F_PC+4 (not-taken path); D_PC<=F_PC; D_instr<=NOP_WORD (delay slot nullified).
- D_flush together with D_isBranch is illegal upstream. If it occurs, D_isBranch wins for NPC and D_flush still nullifies.
- Latency: a redirect takes effect on F_PC one cycle after the branch is in D with stall==0. The delay slot reaches D in the same cycle.
- No internal state beyond the three registers. Everything other than the registers is combinational.

Optional Feature:
- Macro FETCH_ADEL_EN.
- Defined:
  - Adds output F_adel (1 bit, registered with IF/ID, reset 0).
  - F_adel is set when the fetched F_PC[1:0]!=0, or F_PC is outside [PC_RESET, PC_RESET+32'h0000_6FFF].
  - When set, D_instr<=NOP_WORD and D_PC still records the faulting F_PC.
  - F_adel follows the same stall and flush rules as D_instr; flush forces F_adel to 0.
- Undefined: port absent, no range or alignment checks, misaligned PCs are fetched as-is.

Decomposition:
- Shared package/header, extending the existing instruction-type include: PC_RESET default, NOP_WORD, IM address bounds, and the NPC-select encoding (NPC_SEQ, NPC_BR, NPC_J, NPC_JR).
- One natural sub-module: fetch_npc, the combinational NPC mux and adders. The PC and IF/ID registers stay in fetch_redirect.

Test Plan:
- Reset: hold reset=0 two cycles, then release with F_instr=32'h2408_0001 -> F_PC=0x3000, D_instr=0; next edge D_instr=0x24080001, D_PC=0x3000, F_PC=0x3004.
- Taken beq with D_PC=0x3004, D_imm16=16'h0003, D_isBranch=1 -> next F_PC=0x3014; delay slot at 0x3008 enters D unchanged.
- Negative offset D_imm16=16'hFFFF at D_PC=0x3010 -> F_PC=0x3010, checks sign extension.
- Likely not taken: D_flush=1 at D_PC=0x3020, F_PC=0x3024 -> D_instr=0, D_PC=0x3024, F_PC=0x3028.
- Stall with D_flush=1 and D_isBranch=1 for 2 cycles -> all outputs frozen; on release the redirect applies exactly once.
- jr with D_jrTarget=0x3100 plus simultaneous D_isBranch -> F_PC=0x3100 (jr priority). With FETCH_ADEL_EN, D_jrTarget=0x3102 -> next cycle F_adel=1, D_instr=0.
